// File: rtl/fp_pipe_pkg.sv
// Shared definitions for the multi-precision FP pipeline stages:
// per-precision field widths, mode tag encoding and payload sizing.
package fp_pipe_pkg;

  localparam int DP_EXP_W = 11;
  localparam int DP_SUM_W = 52;
  localparam int SP_EXP_W = 8;
  localparam int SP_SUM_W = 23;
  localparam int HP_EXP_W = 5;
  localparam int HP_SUM_W = 10;

  localparam logic [1:0] TAG_HP   = 2'd0;
  localparam logic [1:0] TAG_SP   = 2'd1;
  localparam logic [1:0] TAG_DP   = 2'd2;
  localparam logic [1:0] TAG_RSVD = 2'd3;

  function automatic int payload_w(input int lanes, input int exp_w,
                                   input int sum_w, input int tag_w);
    return lanes * (exp_w + sum_w) + tag_w;
  endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Valid/ready/flush control for a main register plus one skid entry.
// Payload storage lives in the instantiating stage.
module pipe_skid_ctrl
  import fp_pipe_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic load_main,
  output logic load_skid,
  output logic sel_skid
);

  logic main_valid_reg, main_valid_next;
  logic skid_valid_reg, skid_valid_next;
  logic in_ready_reg;
  logic accept;
  logic main_free;

  assign accept    = in_valid & in_ready_reg;
  assign main_free = ~main_valid_reg | out_ready;

  always_comb begin
    main_valid_next = main_valid_reg;
    skid_valid_next = skid_valid_reg;
    load_main       = 1'b0;
    load_skid       = 1'b0;
    sel_skid        = 1'b0;
    if (flush) begin
      // A downstream transfer this cycle still completes; everything else is dropped.
      main_valid_next = 1'b0;
      skid_valid_next = 1'b0;
    end else if (main_free) begin
      if (skid_valid_reg) begin
        load_main       = 1'b1;
        sel_skid        = 1'b1;
        main_valid_next = 1'b1;
        skid_valid_next = 1'b0;
      end else begin
        load_main       = accept;
        main_valid_next = accept;
      end
    end else if (accept) begin
      load_skid       = 1'b1;
      skid_valid_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_valid_reg <= 1'b0;
      skid_valid_reg <= 1'b0;
      in_ready_reg   <= 1'b1;
    end else begin
      main_valid_reg <= main_valid_next;
      skid_valid_reg <= skid_valid_next;
      in_ready_reg   <= ~skid_valid_next;
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid_reg;

endmodule

// File: rtl/fp_lane_pipe_reg.sv
// Multi-lane {exponent, signed sum, tag} pipeline stage with valid/ready
// handshake, 2-entry skid buffering and synchronous flush.
module fp_lane_pipe_reg
  import fp_pipe_pkg::*;
#(
  parameter int LANES = 2,
  parameter int EXP_W = SP_EXP_W,
  parameter int SUM_W = DP_SUM_W,
  parameter int TAG_W = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*EXP_W-1:0] in_exp,
  input  logic [LANES*SUM_W-1:0] in_sum,
  input  logic [TAG_W-1:0]       in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*EXP_W-1:0] out_exp,
  output logic [LANES*SUM_W-1:0] out_sum,
  output logic [TAG_W-1:0]       out_tag
);

  localparam int LANE_W = EXP_W + SUM_W;
  localparam int PAY_W  = payload_w(LANES, EXP_W, SUM_W, TAG_W);

  logic [PAY_W-1:0] in_word;
  logic [PAY_W-1:0] main_reg, main_next;
  logic [PAY_W-1:0] skid_reg;
  logic             load_main, load_skid, sel_skid;

  pipe_skid_ctrl u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .load_main (load_main),
    .load_skid (load_skid),
    .sel_skid  (sel_skid)
  );

  // Lane-major payload packing: each lane is {exp, sum}, tag on top.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign in_word[gi*LANE_W +: LANE_W] = {in_exp[gi*EXP_W +: EXP_W], in_sum[gi*SUM_W +: SUM_W]};
    assign out_sum[gi*SUM_W +: SUM_W]   = main_reg[gi*LANE_W +: SUM_W];
    assign out_exp[gi*EXP_W +: EXP_W]   = main_reg[gi*LANE_W + SUM_W +: EXP_W];
  end

  assign in_word[PAY_W-1 -: TAG_W] = in_tag;
  assign out_tag                   = main_reg[PAY_W-1 -: TAG_W];
  assign main_next                 = sel_skid ? skid_reg : in_word;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_reg <= '0;
      skid_reg <= '0;
    end else begin
      if (load_main) main_reg <= main_next;
      if (load_skid) skid_reg <= in_word;
    end
  end

endmodule

// File: tb/tb_fp_lane_pipe_reg.sv
// Two stage instances (2x8/52 and 4x11/52) driven by shared handshake
// controls and checked against a depth-2 FIFO reference model each.
module tb_fp_lane_pipe_reg;

  localparam int AL = 2, AE = 8,  AS = 52;
  localparam int BL = 4, BE = 11, BS = 52;
  localparam int TW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [TW-1:0] in_tag = '0;

  logic [AL*AE-1:0] a_in_exp = '0, a_out_exp;
  logic [AL*AS-1:0] a_in_sum = '0, a_out_sum;
  logic [TW-1:0]    a_out_tag;
  logic             a_in_ready, a_out_valid;

  logic [BL*BE-1:0] b_in_exp = '0, b_out_exp;
  logic [BL*BS-1:0] b_in_sum = '0, b_out_sum;
  logic [TW-1:0]    b_out_tag;
  logic             b_in_ready, b_out_valid;

  int total = 0;
  int bad   = 0;
  logic [255:0] qa[$];
  logic [255:0] qb[$];

  always #5 clk = ~clk;

  fp_lane_pipe_reg #(.LANES(AL), .EXP_W(AE), .SUM_W(AS), .TAG_W(TW)) u_dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_exp(a_in_exp), .in_sum(a_in_sum), .in_tag(in_tag), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_exp(a_out_exp), .out_sum(a_out_sum), .out_tag(a_out_tag)
  );

  fp_lane_pipe_reg #(.LANES(BL), .EXP_W(BE), .SUM_W(BS), .TAG_W(TW)) u_dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_exp(b_in_exp), .in_sum(b_in_sum), .in_tag(in_tag), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_exp(b_out_exp), .out_sum(b_out_sum), .out_tag(b_out_tag)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_zero();
    chk("rst_a_out_valid", 256'(a_out_valid), 256'(0));
    chk("rst_a_in_ready",  256'(a_in_ready),  256'(1));
    chk("rst_a_data",      256'({a_out_tag, a_out_exp, a_out_sum}), 256'(0));
    chk("rst_b_out_valid", 256'(b_out_valid), 256'(0));
    chk("rst_b_in_ready",  256'(b_in_ready),  256'(1));
    chk("rst_b_data",      256'({b_out_tag, b_out_exp, b_out_sum}), 256'(0));
  endtask

  task automatic randomize_inputs();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    b_in_sum = v[BL*BS-1:0];
    a_in_sum = v[AL*AS+47 -: AL*AS];
    for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
    b_in_exp = v[BL*BE-1:0];
    a_in_exp = v[200 +: AL*AE];
    in_tag   = TW'($urandom_range(0, 3));
  endtask

  // Compare current outputs with the model, then advance one clock.
  task automatic tick();
    logic [255:0] wa, wb;
    bit rdy;
    chk("a_out_valid", 256'(a_out_valid), 256'(qa.size() > 0));
    chk("a_in_ready",  256'(a_in_ready),  256'(qa.size() < 2));
    if (qa.size() > 0) chk("a_data", 256'({a_out_tag, a_out_exp, a_out_sum}), qa[0]);
    chk("b_out_valid", 256'(b_out_valid), 256'(qb.size() > 0));
    chk("b_in_ready",  256'(b_in_ready),  256'(qb.size() < 2));
    if (qb.size() > 0) chk("b_data", 256'({b_out_tag, b_out_exp, b_out_sum}), qb[0]);
    rdy = (qa.size() < 2);
    wa  = 256'({in_tag, a_in_exp, a_in_sum});
    wb  = 256'({in_tag, b_in_exp, b_in_sum});
    @(posedge clk);
    if (!rst) begin
      qa.delete();
      qb.delete();
    end else begin
      if (qa.size() > 0 && out_ready) begin
        $display("xfer a=%h b=%h", qa[0], qb[0]);
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (flush) begin
        qa.delete();
        qb.delete();
      end else if (in_valid && rdy) begin
        qa.push_back(wa);
        qb.push_back(wb);
      end
    end
    #1;
  endtask

  initial begin
    // Reset held with random inputs.
    #2 rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      in_valid  = 1'($urandom);
      out_ready = 1'($urandom);
      chk_reset_zero();
      tick();
    end
    rst = 1'b1;

    // First word after release, then 8 back-to-back directed words.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      logic [51:0] s;
      randomize_inputs();
      s = -52'(k + 5);
      a_in_sum[51:0]  = s;
      b_in_sum[51:0]  = s;
      a_in_exp[15:8]  = 8'h7F;
      b_in_exp[21:11] = 11'h7F;
      b_in_sum[207:156] = {1'b1, 51'b0};
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();

    // Stall with skid: A into main, B into skid, then drain.
    in_valid = 1'b1; out_ready = 1'b0;
    randomize_inputs(); tick();
    randomize_inputs(); tick();
    in_valid = 1'b0;
    chk("skid_a_in_ready", 256'(a_in_ready), 256'(0));
    chk("skid_b_in_ready", 256'(b_in_ready), 256'(0));
    tick();
    out_ready = 1'b1;
    tick(); tick(); tick();

    // Flush with main and skid full and a simultaneous offer.
    in_valid = 1'b1; out_ready = 1'b0;
    randomize_inputs(); tick();
    randomize_inputs(); tick();
    randomize_inputs(); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_a_out_valid", 256'(a_out_valid), 256'(0));
    chk("flush_a_in_ready",  256'(a_in_ready),  256'(1));
    tick(); tick(); tick();

    // Asynchronous reset between edges with main and skid full.
    in_valid = 1'b1; out_ready = 1'b0;
    randomize_inputs(); tick();
    randomize_inputs(); tick();
    in_valid = 1'b0;
    #3 rst = 1'b0;
    #1 chk_reset_zero();
    qa.delete();
    qb.delete();
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    tick(); tick(); tick();

    // Random traffic with occasional flush.
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      tick();
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
